// File: rtl/sdram_rotate_port.sv
// Cornerturn port between a video writer and a video reader sharing one SDRAM command channel.
// Writes go out column-major ({frame, col, row}); reads come back row-major in RD_BURST-word bursts.
module sdram_rotate_port #(
  parameter int HCNT_WIDTH = 10,
  parameter int WR_BURST   = 16,
  parameter int RD_BURST   = 8
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    vidin_req,
  input  logic                    vidin_frame,
  input  logic [HCNT_WIDTH-1:0]   vidin_row,
  input  logic [HCNT_WIDTH-1:0]   vidin_col,
  input  logic [15:0]             vidin_d,
  output logic                    vidin_ack,
  input  logic                    vidout_req,
  input  logic                    vidout_frame,
  input  logic [HCNT_WIDTH-1:0]   vidout_row,
  input  logic [HCNT_WIDTH-1:0]   vidout_col,
  output logic [15:0]             vidout_d,
  output logic                    vidout_ack,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [2*HCNT_WIDTH:0]   mem_addr,
  output logic [15:0]             mem_wdata,
  input  logic                    mem_ack,
  input  logic [15:0]             mem_rdata,
  input  logic                    mem_rvalid
);

  localparam int WCW = $clog2(WR_BURST + 1);
  localparam int RCW = $clog2(RD_BURST + 1);

  typedef enum logic [2:0] {IDLE, WR_SETTLE, WR_CMD, WR_GAP, RD_CMD, RD_DATA} state_t;

  state_t                  state, state_n;
  logic                    phase, phase_n;
  logic [WCW-1:0]          wr_cnt, wr_cnt_n;
  logic [RCW-1:0]          rd_cnt, rd_cnt_n;
  logic [HCNT_WIDTH-1:0]   row_lat, row_lat_n;
  logic                    drop, drop_n;
  logic                    vidin_ack_n, vidout_ack_n, mem_req_n, mem_we_n;
  logic [2*HCNT_WIDTH:0]   mem_addr_n;
  logic [15:0]             mem_wdata_n, vidout_d_n;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      row_lat    <= '0;
      drop       <= 1'b0;
      vidin_ack  <= 1'b0;
      vidout_ack <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      vidout_d   <= '0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      wr_cnt     <= wr_cnt_n;
      rd_cnt     <= rd_cnt_n;
      row_lat    <= row_lat_n;
      drop       <= drop_n;
      vidin_ack  <= vidin_ack_n;
      vidout_ack <= vidout_ack_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      vidout_d   <= vidout_d_n;
    end
  end

  // phase times the two-cycle settle and gap windows; drop makes read-ack suppression sticky
  always_comb begin
    state_n      = state;
    phase_n      = phase;
    wr_cnt_n     = wr_cnt;
    rd_cnt_n     = rd_cnt;
    row_lat_n    = row_lat;
    drop_n       = drop;
    vidin_ack_n  = 1'b0;
    vidout_ack_n = 1'b0;
    mem_req_n    = mem_req;
    mem_we_n     = mem_we;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    vidout_d_n   = vidout_d;
    case (state)
      IDLE: begin
        if (vidin_req) begin
          state_n  = WR_SETTLE;
          phase_n  = 1'b0;
          wr_cnt_n = '0;
        end else if (vidout_req) begin
          state_n    = RD_CMD;
          row_lat_n  = vidout_row;
          mem_addr_n = {vidout_frame, vidout_row, vidout_col};
          mem_req_n  = 1'b1;
          mem_we_n   = 1'b0;
        end
      end
      WR_SETTLE: begin
        if (!vidin_req) begin
          state_n = IDLE;
        end else if (!phase) begin
          phase_n = 1'b1;
        end else begin
          mem_addr_n  = {vidin_frame, vidin_col, vidin_row};
          mem_wdata_n = vidin_d;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b1;
          state_n     = WR_CMD;
        end
      end
      WR_CMD: begin
        if (mem_ack) begin
          mem_req_n   = 1'b0;
          vidin_ack_n = 1'b1;
          phase_n     = 1'b0;
          if (wr_cnt == WCW'(WR_BURST - 1)) begin
            state_n = WR_GAP;
          end else begin
            wr_cnt_n = wr_cnt + 1'b1;
            state_n  = WR_SETTLE;
          end
        end
      end
      WR_GAP: begin
        if (phase) state_n = IDLE;
        else       phase_n = 1'b1;
      end
      RD_CMD: begin
        if (mem_ack) begin
          mem_req_n = 1'b0;
          rd_cnt_n  = '0;
          drop_n    = 1'b0;
          state_n   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (vidout_row != row_lat || !vidout_req) drop_n = 1'b1;
        // the burst is always drained to its full length so the memory side stays in step
        if (mem_rvalid) begin
          vidout_d_n   = mem_rdata;
          vidout_ack_n = !drop_n;
          rd_cnt_n     = rd_cnt + 1'b1;
          if (rd_cnt == RCW'(RD_BURST - 1)) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_rotate_port.sv
// Self-checking bench for sdram_rotate_port: table-driven read bursts plus
// hand-written write, contention, abort, stall and reset sequences.
module tb_sdram_rotate_port;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        vidin_req, vidin_frame;
  logic [9:0]  vidin_row, vidin_col;
  logic [15:0] vidin_d;
  logic        vidin_ack;
  logic        vidout_req, vidout_frame;
  logic [9:0]  vidout_row, vidout_col;
  logic [15:0] vidout_d;
  logic        vidout_ack;
  logic        mem_req, mem_we;
  logic [20:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        frame;
    logic [9:0]  row;
    logic [9:0]  col;
    int          ack_delay;
    bit          gaps;
    int          cut;
    bit          cut_req;
    logic [20:0] exp_addr;
  } rd_vec_t;

  rd_vec_t tbl[4];

  always #5 clk_sys = ~clk_sys;

  sdram_rotate_port dut (
    .clk_sys(clk_sys), .reset(reset),
    .vidin_req(vidin_req), .vidin_frame(vidin_frame), .vidin_row(vidin_row),
    .vidin_col(vidin_col), .vidin_d(vidin_d), .vidin_ack(vidin_ack),
    .vidout_req(vidout_req), .vidout_frame(vidout_frame), .vidout_row(vidout_row),
    .vidout_col(vidout_col), .vidout_d(vidout_d), .vidout_ack(vidout_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // one read transaction; acks stop after 'cut' words via row change or request drop
  task automatic applyStimulus(input rd_vec_t v);
    int waited = 0;
    logic [9:0] c;
    vidout_frame = v.frame;
    vidout_row   = v.row;
    vidout_col   = v.col;
    vidout_req   = 1'b1;
    while (!mem_req && waited < 40) begin
      tick();
      waited++;
    end
    checkOutput("rd_cmd_seen", mem_req, 1);
    if (!mem_req) begin
      vidout_req = 1'b0;
      return;
    end
    checkOutput("rd_we", mem_we, 0);
    checkOutput("rd_addr", mem_addr, v.exp_addr);
    for (int s = 0; s < v.ack_delay; s++) begin
      tick();
      checkOutput("rd_req_hold", mem_req, 1);
      checkOutput("rd_addr_hold", mem_addr, v.exp_addr);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("rd_req_drop", mem_req, 0);
    for (int k = 0; k < 8; k++) begin
      c          = v.col + 10'(k);
      mem_rvalid = 1'b1;
      mem_rdata  = {6'h2C, c};
      tick();
      mem_rvalid = 1'b0;
      if (k < v.cut) begin
        checkOutput("rd_ack", vidout_ack, 1);
        checkOutput("rd_data", vidout_d, {6'h2C, c});
      end else begin
        checkOutput("rd_ack_suppressed", vidout_ack, 0);
      end
      if (k == v.cut - 1) begin
        if (v.cut_req) vidout_req = 1'b0;
        else           vidout_row = v.row ^ 10'h001;
      end
      if (k == 7) vidout_req = 1'b0;
      if (v.gaps) begin
        tick();
        checkOutput("rd_ack_pulse", vidout_ack, 0);
      end
    end
    tick();
    checkOutput("rd_idle_req", mem_req, 0);
    checkOutput("rd_idle_ack", vidout_ack, 0);
  endtask

  // frame 1, row 5, columns 0x3F0.. ; upstream advances col/data on every vidin_ack
  task automatic writeBurst(input int delay, input bit contend);
    int acks = 0, cyc = 0, last = -100, stall = 0;
    logic [20:0] ea;
    vidin_frame = 1'b1;
    vidin_row   = 10'd5;
    vidin_col   = 10'h3F0;
    vidin_d     = 16'hA000;
    if (contend) begin
      vidout_frame = 1'b0;
      vidout_row   = 10'd7;
      vidout_col   = 10'd1020;
      vidout_req   = 1'b1;
    end
    vidin_req = 1'b1;
    while (acks < 16 && cyc < 600) begin
      tick();
      cyc++;
      mem_ack = 1'b0;
      if (vidin_ack) begin
        checkOutput("wr_ack_spacing", (cyc - last) >= 3, 1);
        checkOutput("wr_ack_req_low", mem_req, 0);
        checkOutput("wr_cmd_cycles", stall, delay + 1);
        acks++;
        last = cyc;
        vidin_col++;
        vidin_d++;
        if (acks == 16) vidin_req = 1'b0;
      end
      if (mem_req) begin
        ea = {1'b1, 10'h3F0 + 10'(acks), 10'd5};
        checkOutput("wr_we", mem_we, 1);
        checkOutput("wr_addr", mem_addr, ea);
        checkOutput("wr_data", mem_wdata, 16'hA000 + 16'(acks));
        if (stall == delay) mem_ack = 1'b1;
        stall++;
      end else begin
        stall = 0;
      end
    end
    mem_ack = 1'b0;
    checkOutput("wr_ack_count", acks, 16);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("wr_gap_req", mem_req, 0);
      checkOutput("wr_gap_ack", vidin_ack, 0);
    end
    tick();
    checkOutput("wr_after_gap_req", mem_req, contend ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 10'd7,    10'd1020,  0, 1'b0, 8, 1'b0, 21'h001FFC};
    tbl[1] = '{1'b1, 10'h3FF,  10'd0,     2, 1'b1, 8, 1'b0, 21'h1FFC00};
    tbl[2] = '{1'b0, 10'd0,    10'd5,     0, 1'b0, 3, 1'b0, 21'h000005};
    tbl[3] = '{1'b1, 10'h155,  10'h2AA,   1, 1'b1, 5, 1'b1, 21'h1556AA};

    reset = 1'b1;
    vidin_req = 0; vidin_frame = 0; vidin_row = '0; vidin_col = '0; vidin_d = '0;
    vidout_req = 0; vidout_frame = 0; vidout_row = '0; vidout_col = '0;
    mem_ack = 0; mem_rdata = '0; mem_rvalid = 0;
    repeat (3) tick();
    reset = 1'b0;
    checkOutput("rst_vidin_ack", vidin_ack, 0);
    checkOutput("rst_vidout_ack", vidout_ack, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_vidout_d", vidout_d, 0);
    tick();
    checkOutput("rst_idle_req", mem_req, 0);

    for (int i = 0; i < 4; i++) applyStimulus(tbl[i]);

    writeBurst(0, 1'b0);

    // dropping vidin_req on the second settle cycle must cancel the command
    vidin_frame = 1'b0; vidin_row = 10'd1; vidin_col = 10'd2; vidin_d = 16'h5555;
    vidin_req = 1'b1;
    tick();
    tick();
    vidin_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("abort_req", mem_req, 0);
      checkOutput("abort_ack", vidin_ack, 0);
    end

    writeBurst(10, 1'b0);

    writeBurst(0, 1'b1);
    applyStimulus(tbl[0]);

    // reset while a write command waits for an ack that arrives in the same cycle
    vidin_frame = 1'b0; vidin_row = 10'd3; vidin_col = 10'd9; vidin_d = 16'h1234;
    vidin_req = 1'b1;
    for (int i = 0; i < 10 && !mem_req; i++) tick();
    checkOutput("rstw_req_up", mem_req, 1);
    checkOutput("rstw_addr", mem_addr, 21'h002403);
    checkOutput("rstw_wdata", mem_wdata, 16'h1234);
    repeat (3) tick();
    checkOutput("rstw_req_held", mem_req, 1);
    reset = 1'b1; mem_ack = 1'b1; vidin_req = 1'b0;
    tick();
    reset = 1'b0; mem_ack = 1'b0;
    checkOutput("rstw_mem_req", mem_req, 0);
    checkOutput("rstw_vidin_ack", vidin_ack, 0);
    checkOutput("rstw_mem_we", mem_we, 0);
    checkOutput("rstw_mem_addr", mem_addr, 0);
    checkOutput("rstw_mem_wdata", mem_wdata, 0);
    checkOutput("rstw_vidout_d", vidout_d, 0);
    tick();
    checkOutput("rstw_no_late_ack", vidin_ack, 0);
    checkOutput("rstw_idle_req", mem_req, 0);
    mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("stray_rvalid_ack", vidout_ack, 0);
    checkOutput("stray_rvalid_data", vidout_d, 0);
    tick();
    checkOutput("stray_rvalid_ack2", vidout_ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
